// File: rtl/tx_burst_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tx_burst_scheduler                                              |
// | Purpose  : Round-robin burst scheduler sharing one Interlaken TX lane      |
// |            between N_CH packet channels. Optional macro TX_SCHED_XOFF_EN   |
// |            adds per-channel CH_XOFF flow control on channel selection.     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tx_burst_scheduler #(
  parameter int N_CH      = 2,
  parameter int BURST_MAX = 32
) (
  input  logic                USER_CLK,
  input  logic                SYSTEM_RESET_N,
  input  logic [N_CH-1:0]     CH_VALID,
  input  logic [64*N_CH-1:0]  CH_DATA,
  input  logic [N_CH-1:0]     CH_EOP,
  input  logic [3*N_CH-1:0]   CH_BYTES,
  output logic [N_CH-1:0]     CH_READY,
`ifdef TX_SCHED_XOFF_EN
  input  logic [N_CH-1:0]     CH_XOFF,
`endif
  input  logic                TX_READY,
  output logic                TX_VALID,
  output logic [63:0]         TX_DATA,
  output logic                TX_CTRL
);

  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CNT_W = $clog2(BURST_MAX);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BCW  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CH_W-1:0]  sel_q, sel_d;
  logic [CH_W-1:0]  rr_q, rr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_eop_q, pend_eop_d;
  logic [2:0]       eop_bytes_q, eop_bytes_d;
  logic [N_CH-1:0]  in_pkt_q, in_pkt_d;
  logic [63:0]      cw_q, cw_d;
  logic             burst_q, burst_d;

  logic [N_CH-1:0]  w_elig;
  logic             w_found;
  logic [CH_W-1:0]  w_pick;
  int               w_idx;
  logic [7:0]       w_pick8;
  logic [7:0]       w_sel8;
  logic [3:0]       w_eop_fmt;
  logic             w_accept;
  logic             w_last;

`ifdef TX_SCHED_XOFF_EN
  assign w_elig = CH_VALID & ~CH_XOFF;
`else
  assign w_elig = CH_VALID;
`endif

  // First eligible channel at or above the round-robin pointer, with wrap.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = 0;
    for (int i = 0; i < N_CH; i++) begin
      w_idx = int'(rr_q) + i;
      if (w_idx >= N_CH) w_idx = w_idx - N_CH;
      if (!w_found && w_elig[CH_W'(w_idx)]) begin
        w_found = 1'b1;
        w_pick  = CH_W'(w_idx);
      end
    end
  end

  assign w_pick8   = {{(8-CH_W){1'b0}}, w_pick};
  assign w_sel8    = {{(8-CH_W){1'b0}}, sel_q};
  assign w_eop_fmt = pend_eop_q ? {1'b1, eop_bytes_q} : 4'b0000;
  assign w_accept  = TX_VALID & TX_READY;
  assign w_last    = CH_EOP[sel_q] || (cnt_q == CNT_W'(BURST_MAX-1));

  // Control words come from cw_q; data words pass straight from the selected
  // channel so its own holding register keeps the word stable until taken.
  always_comb begin
    TX_VALID = 1'b0;
    TX_DATA  = '0;
    TX_CTRL  = 1'b0;
    CH_READY = '0;
    case (state_q)
      S_BCW: begin
        TX_VALID = 1'b1;
        TX_DATA  = cw_q;
        TX_CTRL  = 1'b1;
      end
      S_DATA: begin
        TX_VALID = CH_VALID[sel_q];
        TX_DATA  = CH_DATA[64*int'(sel_q) +: 64];
        if (CH_VALID[sel_q] && TX_READY) CH_READY[sel_q] = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    pend_eop_d  = pend_eop_q;
    eop_bytes_d = eop_bytes_q;
    in_pkt_d    = in_pkt_q;
    cw_d        = cw_q;
    burst_d     = burst_q;
    case (state_q)
      S_IDLE: begin
        if (w_found) begin
          sel_d   = w_pick;
          burst_d = 1'b1;
          cw_d    = {2'b11, ~in_pkt_q[w_pick], w_eop_fmt, 17'd0, w_pick8, 32'd0};
          state_d = S_BCW;
        end else if (pend_eop_q) begin
          burst_d = 1'b0;
          cw_d    = {2'b10, 1'b0, w_eop_fmt, 17'd0, w_sel8, 32'd0};
          state_d = S_BCW;
        end
      end
      S_BCW: begin
        if (w_accept) begin
          pend_eop_d = 1'b0;
          cnt_d      = '0;
          state_d    = burst_q ? S_DATA : S_IDLE;
        end
      end
      S_DATA: begin
        if (w_accept) begin
          cnt_d = cnt_q + 1'b1;
          if (w_last) begin
            state_d = S_IDLE;
            rr_d    = (sel_q == CH_W'(N_CH-1)) ? '0 : sel_q + 1'b1;
            // EOP wins when it coincides with the BURST_MAX boundary.
            if (CH_EOP[sel_q]) begin
              pend_eop_d      = 1'b1;
              eop_bytes_d     = CH_BYTES[3*int'(sel_q) +: 3];
              in_pkt_d[sel_q] = 1'b0;
            end else begin
              in_pkt_d[sel_q] = 1'b1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
    if (!SYSTEM_RESET_N) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      rr_q        <= '0;
      cnt_q       <= '0;
      pend_eop_q  <= 1'b0;
      eop_bytes_q <= 3'd0;
      in_pkt_q    <= '0;
      cw_q        <= '0;
      burst_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      pend_eop_q  <= pend_eop_d;
      eop_bytes_q <= eop_bytes_d;
      in_pkt_q    <= in_pkt_d;
      cw_q        <= cw_d;
      burst_q     <= burst_d;
    end
  end

endmodule
`default_nettype wire
